pulse_train_gen_fsm: RTL and testbench

Registered pulse generator that is the transmit side of our rising-edge detection path. Each single-cycle `edge_req` pulse produces exactly one clean high pulse on `signal_out`, with a guaranteed low gap after it. This lets a downstream edge-detector FSM see exactly one rising edge per accepted request. Requests that arrive while a pulse is in flight are buffered in a small pending counter; requests beyond its capacity are dropped and flagged.

---
 rtl/pulse_train_gen_fsm.sv | 122 ++++++++++++
 tb/tb_pulse_train_gen_fsm.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen_fsm.sv
// Pulse generator: one clean HIGH_CYCLES-wide pulse per accepted edge_req, followed by
// a guaranteed LOW_CYCLES gap. Requests seen mid-pulse wait in a saturating pending counter.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no pulse in flight, signal_out low
//   S_HIGH | pulse in flight, signal_out high, cnt counts down the width
//   S_LOW  | enforced low gap after a pulse, cnt counts down the gap
module pulse_train_gen_fsm #(
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 1,
    parameter int PEND_MAX    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              edge_req,
    output logic                              signal_out,
    output logic                              busy,
    output logic [$clog2(PEND_MAX+1)-1:0]     pend_cnt,
    output logic                              overflow
);

    localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PEND_W  = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              consume;
    logic              buffer_req;
    logic              ovf_nxt;
    logic              sig_nxt;
    logic              busy_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        consume   = 1'b0;
        case (state)
            S_IDLE: begin
                // A leftover pending request in IDLE is started as if freshly requested.
                if (edge_req || (pend_cnt != '0)) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = HIGH_LOAD;
                    consume   = !edge_req;
                end
            end
            S_HIGH: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = S_LOW;
                    cnt_nxt   = LOW_LOAD;
                end
            end
            S_LOW: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (pend_cnt != '0) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = HIGH_LOAD;
                    consume   = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        buffer_req = edge_req && (state != S_IDLE);
        pend_nxt   = pend_cnt;
        ovf_nxt    = 1'b0;
        // A request landing on a consume edge replaces the consumed one, so it never overflows.
        if (buffer_req && !consume) begin
            if (pend_cnt == PEND_FULL) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_nxt = pend_cnt + 1'b1;
            end
        end else if (!buffer_req && consume) begin
            pend_nxt = pend_cnt - 1'b1;
        end

        sig_nxt  = (state_nxt == S_HIGH);
        busy_nxt = (state_nxt != S_IDLE) || (pend_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pend_cnt   <= '0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pend_cnt   <= pend_nxt;
            signal_out <= sig_nxt;
            busy       <= busy_nxt;
            overflow   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen_fsm.sv
// Bench for pulse_train_gen_fsm: directed edge-timed scenarios plus a random request stream
// checked against a time-based pulse schedule model and a downstream edge-detector FSM.
module tb_pulse_train_gen_fsm;

    localparam int H = 2;
    localparam int L = 1;
    localparam int P = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       edge_req = 1'b0;
    logic       signal_out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    pulse_train_gen_fsm #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .PEND_MAX    (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .edge_req   (edge_req),
        .signal_out (signal_out),
        .busy       (busy),
        .pend_cnt   (pend_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Downstream consumer: counts rising edges of signal_out
    typedef enum logic {D_WAIT_RISE, D_WAIT_FALL} det_t;
    det_t det_state;
    int   det_cnt;
    always @(posedge clk) begin
        if (rst) begin
            det_state <= D_WAIT_RISE;
            det_cnt   <= 0;
        end else begin
            case (det_state)
                D_WAIT_RISE: if (signal_out === 1'b1) begin
                    det_state <= D_WAIT_FALL;
                    det_cnt   <= det_cnt + 1;
                end
                default: if (signal_out === 1'b0) det_state <= D_WAIT_RISE;
            endcase
        end
    end

    // Reference model: a pulse started at edge s is high after edges s..s+H-1, low through
    // s+H+L-1, and edge s+H+L is the earliest edge at which the next pulse may start.
    int   m_t = 0;
    int   m_start = -1;
    int   m_pend = 0;
    int   m_reqs = 0;
    int   m_drops = 0;
    logic m_ovf = 1'b0;
    logic m_sig = 1'b0;
    logic m_busy = 1'b0;

    int   rises, last_rise, min_space, min_high, max_high, high_len;
    logic prev_sig = 1'b0;

    task automatic clear_stats();
        rises = 0; last_rise = -1; min_space = 1000000;
        min_high = 1000000; max_high = 0; high_len = 0;
        m_reqs = 0; m_drops = 0;
    endtask

    task automatic tick(input logic req, input logic r);
        bit in_pulse;
        bit cons;
        edge_req = req;
        rst      = r;
        @(posedge clk);
        #1;
        m_t++;
        m_ovf = 1'b0;
        if (r) begin
            m_start = -1;
            m_pend  = 0;
        end else begin
            in_pulse = (m_start >= 0) && (m_t - m_start <= H + L);
            if (in_pulse) begin
                cons = (m_t - m_start == H + L) && (m_pend > 0);
                if (cons) m_start = m_t;
                if (req) begin
                    m_reqs++;
                    if (!cons) begin
                        if (m_pend == P) begin
                            m_ovf = 1'b1;
                            m_drops++;
                        end else begin
                            m_pend++;
                        end
                    end
                end else if (cons) begin
                    m_pend--;
                end
            end else if (req || m_pend > 0) begin
                if (req) m_reqs++;
                else m_pend--;
                m_start = m_t;
            end
        end
        m_sig  = (m_start >= 0) && (m_t - m_start < H);
        m_busy = ((m_start >= 0) && (m_t - m_start < H + L)) || (m_pend > 0);

        if (signal_out === 1'b1 && prev_sig !== 1'b1) begin
            rises++;
            if (last_rise >= 0 && (m_t - last_rise) < min_space) min_space = m_t - last_rise;
            last_rise = m_t;
            high_len  = 1;
        end else if (signal_out === 1'b1) begin
            high_len++;
        end else if (prev_sig === 1'b1) begin
            if (high_len < min_high) min_high = high_len;
            if (high_len > max_high) max_high = high_len;
        end
        prev_sig = signal_out;
    endtask

    // Packed view {signal_out, busy, pend_cnt, overflow} used by directed tables
    task automatic test_reset();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tests++;
        if ({signal_out, busy, pend_cnt, overflow} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 00000", {signal_out, busy, pend_cnt, overflow});
        end
        tick(1'b0, 1'b0);
        tests++;
        if ({signal_out, busy, pend_cnt, overflow} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_idle: got %b expected 00000", {signal_out, busy, pend_cnt, overflow});
        end
    endtask

    task automatic test_single();
        logic [4:0] exp_v [0:3];
        exp_v = '{5'b11000, 5'b11000, 5'b01000, 5'b00000};
        tick(1'b0, 1'b1);
        clear_stats();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int e = 3; e <= 6; e++) begin
            tick(e == 3, 1'b0);
            tests++;
            if ({signal_out, busy, pend_cnt, overflow} !== exp_v[e-3]) begin
                fails++;
                $display("FAIL single edge %0d: got %b expected %b", e,
                         {signal_out, busy, pend_cnt, overflow}, exp_v[e-3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_v [0:6];
        exp_v = '{5'b11000, 5'b11010, 5'b01010, 5'b11000, 5'b11000, 5'b01000, 5'b00000};
        tick(1'b0, 1'b1);
        clear_stats();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int e = 3; e <= 9; e++) begin
            tick(e == 3 || e == 4, 1'b0);
            tests++;
            if ({signal_out, busy, pend_cnt, overflow} !== exp_v[e-3]) begin
                fails++;
                $display("FAIL back_to_back edge %0d: got %b expected %b", e,
                         {signal_out, busy, pend_cnt, overflow}, exp_v[e-3]);
            end
        end
        tests++;
        if (rises !== 2) begin
            fails++;
            $display("FAIL back_to_back rises: got %0d expected 2", rises);
        end
    endtask

    task automatic test_held();
        logic [4:0] exp_v [0:15];
        exp_v = '{5'b11000, 5'b11010, 5'b01100, 5'b11100, 5'b11110, 5'b01111, 5'b11100,
                  5'b11100, 5'b01100, 5'b11010, 5'b11010, 5'b01010, 5'b11000, 5'b11000,
                  5'b01000, 5'b00000};
        tick(1'b0, 1'b1);
        clear_stats();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int e = 3; e <= 18; e++) begin
            tick(e >= 3 && e <= 8, 1'b0);
            tests++;
            if ({signal_out, busy, pend_cnt, overflow} !== exp_v[e-3]) begin
                fails++;
                $display("FAIL held edge %0d: got %b expected %b", e,
                         {signal_out, busy, pend_cnt, overflow}, exp_v[e-3]);
            end
        end
        tests++;
        if (rises !== 5) begin
            fails++;
            $display("FAIL held rises: got %0d expected 5", rises);
        end
    endtask

    task automatic test_consume_full();
        logic [4:0] exp_v [0:2];
        exp_v = '{5'b01111, 5'b11110, 5'b11110};
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int e = 3; e <= 10; e++) begin
            tick(e <= 9, 1'b0);
            if (e >= 8) begin
                tests++;
                if ({signal_out, busy, pend_cnt, overflow} !== exp_v[e-8]) begin
                    fails++;
                    $display("FAIL consume_full edge %0d: got %b expected %b", e,
                             {signal_out, busy, pend_cnt, overflow}, exp_v[e-8]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp_v [0:6];
        exp_v = '{5'b01100, 5'b00000, 5'b00000, 5'b11000, 5'b11000, 5'b01000, 5'b00000};
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int e = 3; e <= 9; e++) begin
            tick(e == 3 || e == 6, e == 4);
            tests++;
            if ({signal_out, busy, pend_cnt, overflow} !== exp_v[e-3]) begin
                fails++;
                $display("FAIL reset_mid edge %0d: got %b expected %b", e,
                         {signal_out, busy, pend_cnt, overflow}, exp_v[e-3]);
            end
        end
    endtask

    task automatic test_random();
        int   thr;
        logic req;
        int   accepted;
        tick(1'b0, 1'b1);
        clear_stats();
        for (int i = 0; i < 520; i++) begin
            thr = (i < 150) ? 25 : (i < 350) ? 70 : (i < 500) ? 95 : 0;
            req = ($urandom_range(0, 99) < thr);
            tick(req, 1'b0);
            tests++;
            if ({signal_out, busy, pend_cnt, overflow} !== {m_sig, m_busy, 2'(m_pend), m_ovf}) begin
                fails++;
                $display("FAIL random cycle %0d: got %b expected %b", i,
                         {signal_out, busy, pend_cnt, overflow}, {m_sig, m_busy, 2'(m_pend), m_ovf});
            end
        end
        accepted = m_reqs - m_drops;
        tests++;
        if (rises !== accepted) begin
            fails++;
            $display("FAIL random rise_count: got %0d expected %0d", rises, accepted);
        end
        tests++;
        if (det_cnt !== accepted) begin
            fails++;
            $display("FAIL random detector_count: got %0d expected %0d", det_cnt, accepted);
        end
        tests++;
        if (min_high !== H || max_high !== H) begin
            fails++;
            $display("FAIL random high_width: got min %0d max %0d expected %0d", min_high, max_high, H);
        end
        tests++;
        if (min_space < H + L) begin
            fails++;
            $display("FAIL random spacing: got %0d expected >= %0d", min_space, H + L);
        end
        tests++;
        if (m_drops == 0 || rises < 10) begin
            fails++;
            $display("FAIL random stimulus_coverage: got drops %0d rises %0d expected >0 and >=10",
                     m_drops, rises);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single();
        test_back_to_back();
        test_held();
        test_consume_full();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
